tt_um_alu_kdcastillor: RTL and testbench

8-bit registered ALU for a TinyTapeout-style tile: two operand registers loaded over the dedicated input bus, sixteen arithmetic/logic/shift operations, registered result and status flags. All add/subtract/increment/decrement paths share one 8-stage ripple chain of 1-bit full adders. The block is the top-level user module and connects directly to the tile I/O ring.

---
 rtl/tt_um_alu_kdcastillor.sv | 136 +++++++++++++
 tb/tb_tt_um_alu_kdcastillor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tt_um_alu_kdcastillor.sv
// 8-bit registered ALU tile: operand registers A/B loaded over ui_in, sixteen operations,
// registered result and C/Z/N/V flags. All add/sub/inc/dec share one ripple-carry chain.
module tt_um_alu_kdcastillor (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    CmdIdle  = 2'b00,
    CmdLoadA = 2'b01,
    CmdLoadB = 2'b10,
    CmdExec  = 2'b11
  } cmd_e;

  typedef enum logic [3:0] {
    OpAdd   = 4'h0,
    OpAdc   = 4'h1,
    OpSub   = 4'h2,
    OpSbc   = 4'h3,
    OpAnd   = 4'h4,
    OpOr    = 4'h5,
    OpXor   = 4'h6,
    OpNot   = 4'h7,
    OpShl   = 4'h8,
    OpShr   = 4'h9,
    OpAsr   = 4'hA,
    OpRol   = 4'hB,
    OpRor   = 4'hC,
    OpInc   = 4'hD,
    OpDec   = 4'hE,
    OpPassB = 4'hF
  } op_e;

  logic [7:0] a_q, b_q, r_q;
  logic       c_q, z_q, n_q, v_q;

  cmd_e       cmd;
  op_e        op;
  logic       cin;

  logic [7:0] add_x, add_y;
  logic       add_ci;
  logic [7:0] add_sum;
  logic [8:0] carry;

  logic [7:0] r_d;
  logic       c_d, v_d;

  assign cmd = cmd_e'(uio_in[1:0]);
  assign op  = op_e'(ui_in[3:0]);
  assign cin = uio_in[2];

  // Adder operand selection; non-adder opcodes leave the chain idle on A + 0.
  always_comb begin
    add_x  = a_q;
    add_y  = 8'h00;
    add_ci = 1'b0;
    unique case (op)
      OpAdd:   begin add_y = b_q;    add_ci = 1'b0; end
      OpAdc:   begin add_y = b_q;    add_ci = cin;  end
      OpSub:   begin add_y = ~b_q;   add_ci = 1'b1; end
      OpSbc:   begin add_y = ~b_q;   add_ci = cin;  end
      OpInc:   begin add_y = 8'h00;  add_ci = 1'b1; end
      OpDec:   begin add_y = 8'hFF;  add_ci = 1'b0; end
      default: begin add_y = 8'h00;  add_ci = 1'b0; end
    endcase
  end

  // Shared 8-stage ripple chain of 1-bit full adders.
  assign carry[0] = add_ci;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign add_sum[i]  = add_x[i] ^ add_y[i] ^ carry[i];
    assign carry[i+1]  = (add_x[i] & add_y[i]) | (carry[i] & (add_x[i] ^ add_y[i]));
  end

  always_comb begin
    r_d = 8'h00;
    c_d = 1'b0;
    v_d = 1'b0;
    unique case (op)
      OpAdd, OpAdc, OpSub, OpSbc, OpInc, OpDec: begin
        r_d = add_sum;
        c_d = carry[8];
        v_d = (add_x[7] == add_y[7]) && (add_sum[7] != add_x[7]);
      end
      OpAnd:   r_d = a_q & b_q;
      OpOr:    r_d = a_q | b_q;
      OpXor:   r_d = a_q ^ b_q;
      OpNot:   r_d = ~a_q;
      OpShl:   begin r_d = {a_q[6:0], 1'b0};     c_d = a_q[7]; end
      OpShr:   begin r_d = {1'b0, a_q[7:1]};     c_d = a_q[0]; end
      OpAsr:   begin r_d = {a_q[7], a_q[7:1]};   c_d = a_q[0]; end
      OpRol:   begin r_d = {a_q[6:0], a_q[7]};   c_d = a_q[7]; end
      OpRor:   begin r_d = {a_q[0], a_q[7:1]};   c_d = a_q[0]; end
      OpPassB: r_d = b_q;
      default: r_d = 8'h00;
    endcase
  end

  // rst_n is active-high here despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q <= 8'h00;
      b_q <= 8'h00;
      r_q <= 8'h00;
      c_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else if (ena) begin
      unique case (cmd)
        CmdLoadA: a_q <= ui_in;
        CmdLoadB: b_q <= ui_in;
        CmdExec: begin
          r_q <= r_d;
          c_q <= c_d;
          z_q <= (r_d == 8'h00);
          n_q <= r_d[7];
          v_q <= v_d;
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = r_q;
  assign uio_out = {c_q, z_q, n_q, v_q, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_alu_kdcastillor.sv
// Directed self-checking bench for the ALU tile: loads, every opcode class, flags,
// asynchronous mid-sequence reset and clock-enable hold.
module tb_tt_um_alu_kdcastillor;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int checks = 0;
  int errors = 0;

  tt_um_alu_kdcastillor dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks result, flags and the constant output-enable together.
  task automatic expect_out(input string tag, input logic [7:0] exp_r, input logic [7:0] exp_f);
    check({tag, " uo_out"}, uo_out, exp_r);
    check({tag, " uio_out"}, uio_out, exp_f);
    check({tag, " uio_oe"}, uio_oe, 8'hF0);
  endtask

  // One command on one edge; junk in uio_in[7:3] must be ignored by the DUT.
  task automatic send(input logic [1:0] c, input logic [7:0] d, input logic ci);
    ui_in  = d;
    uio_in = {5'b10110, ci, c};
    @(posedge clk);
    #1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic load_a(input logic [7:0] d);
    send(2'b01, d, 1'b0);
  endtask

  task automatic load_b(input logic [7:0] d);
    send(2'b10, d, 1'b0);
  endtask

  // Upper opcode nibble set to junk as well.
  task automatic exec(input logic [3:0] op, input logic ci);
    send(2'b11, {4'hA, op}, ci);
  endtask

  initial begin
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    rst_n  = 1'b1;
    #2;
    expect_out("reset", 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;

    // Add / overflow
    load_a(8'h7F);
    load_b(8'h01);
    exec(4'h0, 1'b1);
    expect_out("add 7f+01", 8'h80, 8'h30);
    exec(4'h1, 1'b1);
    expect_out("adc 7f+01+1", 8'h81, 8'h30);
    exec(4'h0, 1'b1);
    expect_out("add ignores cin", 8'h80, 8'h30);

    // Subtract
    load_a(8'h05);
    load_b(8'h05);
    exec(4'h2, 1'b0);
    expect_out("sub 05-05", 8'h00, 8'hC0);
    load_a(8'h00);
    load_b(8'h01);
    exec(4'h2, 1'b0);
    expect_out("sub 00-01", 8'hFF, 8'h20);
    exec(4'h3, 1'b0);
    expect_out("sbc 00-01-1", 8'hFE, 8'h20);

    // Increment / decrement
    load_a(8'hFF);
    exec(4'hD, 1'b0);
    expect_out("inc ff", 8'h00, 8'hC0);
    load_a(8'h80);
    exec(4'hE, 1'b0);
    expect_out("dec 80", 8'h7F, 8'h90);
    load_a(8'h00);
    exec(4'hE, 1'b0);
    expect_out("dec 00", 8'hFF, 8'h20);

    // Logic
    load_a(8'hF0);
    load_b(8'h3C);
    exec(4'h4, 1'b1);
    expect_out("and", 8'h30, 8'h00);
    exec(4'h5, 1'b1);
    expect_out("or", 8'hFC, 8'h20);
    exec(4'h6, 1'b1);
    expect_out("xor", 8'hCC, 8'h20);
    exec(4'h7, 1'b1);
    expect_out("not", 8'h0F, 8'h00);
    exec(4'hF, 1'b1);
    expect_out("passb", 8'h3C, 8'h00);

    // Shifts and rotates
    load_a(8'h81);
    exec(4'h8, 1'b0);
    expect_out("shl", 8'h02, 8'h80);
    exec(4'h9, 1'b0);
    expect_out("shr", 8'h40, 8'h80);
    exec(4'hA, 1'b0);
    expect_out("asr", 8'hC0, 8'hA0);
    exec(4'hB, 1'b0);
    expect_out("rol", 8'h03, 8'h80);
    exec(4'hC, 1'b0);
    expect_out("ror", 8'hC0, 8'hA0);

    // Clock enable low: load and execute both ignored
    ena = 1'b0;
    load_a(8'h00);
    expect_out("ena0 load", 8'hC0, 8'hA0);
    exec(4'h7, 1'b0);
    expect_out("ena0 exec", 8'hC0, 8'hA0);
    ena = 1'b1;
    exec(4'h7, 1'b0);
    expect_out("a held under ena0", 8'h7E, 8'h00);

    // Asynchronous reset between edges, held across an edge
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_out("async reset", 8'h00, 8'h00);
    load_a(8'h55);
    expect_out("reset held", 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exec(4'hF, 1'b0);
    expect_out("b cleared", 8'h00, 8'h40);
    exec(4'h7, 1'b0);
    expect_out("a cleared", 8'hFF, 8'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
